count_uart_reporter: RTL and testbench

- Downstream consumer of the 4-bit up-counter.
- Watches the counter value and reports every new value on a serial UART TX line.
- Each report is one ASCII hex digit followed by LF (0x0A), sent 8N1, LSB first.
- Lets the counter be observed on a terminal or by a bench UART monitor without $display.

---
 rtl/count_uart_reporter.sv | 169 ++++++++++++++++
 tb/tb_count_uart_reporter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/count_uart_reporter.sv
// Reports each new value of a 4-bit counter on a UART TX line as an ASCII
// hex digit followed by LF, 8N1, LSB first. The newest value wins when
// changes arrive faster than the reports.
module count_uart_reporter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] count,
    output logic       tx,
    output logic       busy,
    output logic [7:0] overrun_count
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [3:0]    prev;
    logic [3:0]    pend_val, pend_val_n;
    logic          pending, pending_n;
    logic          byte_sel, byte_sel_n;
    logic [7:0]    shift, shift_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          consume;
    logic          change;
    logic          tx_n;
    logic          busy_n;
    logic [7:0]    overrun_n;

    function automatic logic [7:0] to_ascii(input logic [3:0] v);
        if (v < 4'd10)
            return {4'h3, v};
        else
            return 8'h37 + {4'h0, v};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // An unknown comparison result falls through the if and counts as no change.
    always_comb begin
        change = 1'b0;
        if (count != prev)
            change = 1'b1;
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        byte_sel_n = byte_sel;
        timer_n    = timer;
        bit_idx_n  = bit_idx;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    shift_n    = to_ascii(pend_val);
                    consume    = 1'b1;
                    byte_sel_n = 1'b0;
                    timer_n    = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (timer == T_LAST) begin
                    timer_n   = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    timer_n = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer == T_LAST) begin
                    timer_n = '0;
                    if (!byte_sel) begin
                        shift_n    = 8'h0A;
                        byte_sel_n = 1'b1;
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A change landing on the consuming edge re-arms pending without an overrun.
    always_comb begin
        pending_n  = pending;
        pend_val_n = pend_val;
        overrun_n  = overrun_count;
        if (change) begin
            pending_n  = 1'b1;
            pend_val_n = count;
            if (pending && !consume)
                overrun_n = sat_inc(overrun_count);
        end else if (consume) begin
            pending_n = 1'b0;
        end
    end

    // Line level is decoded from the next state so tx and busy leave flops directly.
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= 1'b0;
            byte_sel      <= 1'b0;
            timer         <= '0;
            bit_idx       <= 3'd0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            overrun_count <= 8'd0;
        end else begin
            state         <= state_n;
            pending       <= pending_n;
            byte_sel      <= byte_sel_n;
            timer         <= timer_n;
            bit_idx       <= bit_idx_n;
            tx            <= tx_n;
            busy          <= busy_n;
            overrun_count <= overrun_n;
        end
    end

    // prev tracks count through reset so the value at release is never reported.
    always_ff @(posedge clock) begin
        if (reset || change)
            prev <= count;
        shift    <= shift_n;
        pend_val <= pend_val_n;
    end

endmodule

// File: tb/tb_count_uart_reporter.sv
// Directed bench for count_uart_reporter: decodes the TX line with a
// background UART receiver and checks frames, timing and overrun counting.
`timescale 1ns/1ps
module tb_count_uart_reporter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count = 4'd0;
    logic       tx;
    logic       busy;
    logic [7:0] overrun_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rxq[$];
    time        stq[$];
    int         frame_err = 0;
    logic [7:0] mon_b;
    logic       mon_ok;
    time        mon_t;

    count_uart_reporter #(.CLKS_PER_BIT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .count         (count),
        .tx            (tx),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #5 clock = ~clock;

    // Receiver: first low sample is start-bit cycle 0; sample mid-bit (cycle 2 of 4).
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && tx === 1'b0) begin
                mon_t  = $time;
                mon_ok = 1'b1;
                repeat (2) @(negedge clock);
                if (tx !== 1'b0) mon_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clock);
                    mon_b[i] = tx;
                end
                repeat (4) @(negedge clock);
                if (tx !== 1'b1) mon_ok = 1'b0;
                rxq.push_back(mon_b);
                stq.push_back(mon_t);
                if (!mon_ok) frame_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] c, input int n);
        @(negedge clock);
        reset = 1'b1;
        count = c;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int p);
        if (p < 4) return 1'b0;
        if (p < 36) return b[(p - 4) / 4];
        return 1'b1;
    endfunction

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46);
    endfunction

    int         bad;
    int         nonmono;
    logic [7:0] last_ov;
    logic [7:0] eb;

    initial begin
        // Test 1: value present at reset release is never reported
        do_reset(4'd7, 5);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ovr", {24'd0, overrun_count}, 32'd0);
        bad = 0;
        repeat (500) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t1_quiet_cycles_bad", bad, 0);
        check("t1_no_frames", rxq.size(), 0);
        check("t1_ovr", {24'd0, overrun_count}, 32'd0);

        // Test 2: exact waveform for '5' + LF
        do_reset(4'd0, 2);
        rxq.delete(); stq.delete();
        count = 4'd5;
        @(negedge clock);
        check("t2_tx_after_detect", {31'd0, tx}, 32'd1);
        check("t2_busy_after_detect", {31'd0, busy}, 32'd0);
        for (int j = 0; j < 80; j++) begin
            @(negedge clock);
            eb = (j < 40) ? 8'h35 : 8'h0A;
            check($sformatf("t2_tx_c%0d", j), {31'd0, tx}, {31'd0, exp_bit(eb, j % 40)});
            check($sformatf("t2_busy_c%0d", j), {31'd0, busy}, 32'd1);
        end
        @(negedge clock);
        check("t2_busy_end", {31'd0, busy}, 32'd0);
        check("t2_tx_end", {31'd0, tx}, 32'd1);
        repeat (20) @(negedge clock);
        check("t2_nbytes", rxq.size(), 2);
        if (rxq.size() == 2) begin
            check("t2_b0", {24'd0, rxq[0]}, 32'h35);
            check("t2_b1", {24'd0, rxq[1]}, 32'h0A);
        end
        check("t2_ovr", {24'd0, overrun_count}, 32'd0);

        // Test 3: 0->1->2->3 on consecutive cycles; 2 is overwritten
        do_reset(4'd0, 2);
        rxq.delete(); stq.delete();
        count = 4'd1;
        @(negedge clock); count = 4'd2;
        @(negedge clock); count = 4'd3;
        repeat (250) @(negedge clock);
        check("t3_nbytes", rxq.size(), 4);
        if (rxq.size() == 4) begin
            check("t3_b0", {24'd0, rxq[0]}, 32'h31);
            check("t3_b1", {24'd0, rxq[1]}, 32'h0A);
            check("t3_b2", {24'd0, rxq[2]}, 32'h33);
            check("t3_b3", {24'd0, rxq[3]}, 32'h0A);
            check("t3_lf_offset", 32'(int'(stq[1] - stq[0])), 32'd400);
            check("t3_report_gap", 32'(int'(stq[2] - stq[0])), 32'd810);
        end
        check("t3_ovr", {24'd0, overrun_count}, 32'd1);
        check("t3_frame_err", frame_err, 0);

        // Test 4: wrap-around 14->15->0
        do_reset(4'd14, 2);
        rxq.delete(); stq.delete();
        count = 4'd15;
        repeat (200) @(negedge clock);
        count = 4'd0;
        repeat (200) @(negedge clock);
        check("t4_nbytes", rxq.size(), 4);
        if (rxq.size() == 4) begin
            check("t4_b0", {24'd0, rxq[0]}, 32'h46);
            check("t4_b1", {24'd0, rxq[1]}, 32'h0A);
            check("t4_b2", {24'd0, rxq[2]}, 32'h30);
            check("t4_b3", {24'd0, rxq[3]}, 32'h0A);
        end
        check("t4_ovr", {24'd0, overrun_count}, 32'd0);

        // Test 5: reset during data bit 3 of '9' (0x39)
        do_reset(4'd0, 2);
        count = 4'd9;
        @(negedge clock);
        @(negedge clock);
        check("t5_start_tx", {31'd0, tx}, 32'd0);
        check("t5_start_busy", {31'd0, busy}, 32'd1);
        repeat (17) @(negedge clock);
        check("t5_bit3_tx", {31'd0, tx}, 32'd1);
        check("t5_bit3_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("t5_reset_tx", {31'd0, tx}, 32'd1);
        check("t5_reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t5_no_frame_after", bad, 0);

        // Test 6: change every cycle; overrun saturates, frames stay well formed
        do_reset(4'd0, 2);
        rxq.delete(); stq.delete();
        frame_err = 0;
        nonmono = 0;
        last_ov = 8'd0;
        for (int i = 0; i < 30000; i++) begin
            count = count + 4'd1;
            @(negedge clock);
            if (overrun_count < last_ov) nonmono++;
            last_ov = overrun_count;
        end
        check("t6_ovr_sat", {24'd0, overrun_count}, 32'd255);
        check("t6_ovr_monotonic", nonmono, 0);
        repeat (250) @(negedge clock);
        check("t6_ovr_hold", {24'd0, overrun_count}, 32'd255);
        check("t6_even_bytes", rxq.size() % 2, 0);
        check("t6_many_frames", {31'd0, rxq.size() > 100}, 32'd1);
        if (rxq.size() > 0)
            check("t6_first_digit", {24'd0, rxq[0]}, 32'h31);
        bad = 0;
        for (int i = 0; i + 1 < rxq.size(); i += 2) begin
            if (!is_hex(rxq[i]) || rxq[i+1] !== 8'h0A) bad++;
        end
        check("t6_bad_frames", bad, 0);
        check("t6_frame_err", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
